// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: CoreSPI register map, status bits and sequencer state encoding.
// Revision: 1.0
`default_nettype none

package spi_seq_pkg;

  localparam logic [6:0] REG_CONTROL = 7'h00;
  localparam logic [6:0] REG_RXDATA  = 7'h08;
  localparam logic [6:0] REG_TXDATA  = 7'h0C;
  localparam logic [6:0] REG_STATUS  = 7'h24;
  localparam logic [6:0] REG_SSEL    = 7'h28;
  localparam logic [6:0] REG_CLKGEN  = 7'h30;

  localparam int          STATUS_RXEMPTY = 2;
  localparam logic [31:0] CONTROL_INIT   = 32'h0000_0003;
  localparam logic [8:0]  HDR_BYTES      = 9'd4;

  typedef enum logic [3:0] {
    ST_INIT_CLK  = 4'd0,
    ST_INIT_CTRL = 4'd1,
    ST_IDLE      = 4'd2,
    ST_SSEL_ON   = 4'd3,
    ST_TX_WR     = 4'd4,
    ST_POLL      = 4'd5,
    ST_RX_RD     = 4'd6,
    ST_OUT       = 4'd7,
    ST_SSEL_OFF  = 4'd8
  } state_t;

  // Command, then address MSB first, then dummy bytes that clock in read data.
  function automatic logic [7:0] tx_byte(input logic [8:0] idx, input logic [7:0] cmd,
                                         input logic [23:0] addr);
    case (idx)
      9'd0:    return cmd;
      9'd1:    return addr[23:16];
      9'd2:    return addr[15:8];
      9'd3:    return addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_master_port.sv
// apb_master_port: single-access APB master (SETUP then ACCESS until pready).
// Revision: 1.0
`default_nettype none

module apb_master_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        slverr,
  output logic        busy,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [6:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (!psel) begin
      if (start) begin
        psel   <= 1'b1;
        pwrite <= write;
        paddr  <= addr;
        pwdata <= wdata;
      end
    end else if (!penable) begin
      penable <= 1'b1;
    end else if (pready) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

  // Completion is combinational so the caller can issue the next access after one idle cycle.
  assign done   = psel & penable & pready;
  assign rdata  = prdata;
  assign slverr = done & pslverr;
  assign busy   = psel;

endmodule

`default_nettype wire

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: drives CoreSPI over APB to perform one flash read per request.
// Revision: 1.0
`default_nettype none

module spi_flash_sequencer
  import spi_seq_pkg::*;
#(
  parameter int CLKGEN_DIV = 4,
  parameter int POLL_LIMIT = 1023
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  m_paddr,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr
);

  state_t      state, state_nx;
  logic [7:0]  cmd_q, len_q;
  logic [23:0] addr_q;
  logic [8:0]  idx;
  logic [15:0] poll_cnt;
  logic        err_flag;

  logic        access, apb_start, apb_write, apb_done, apb_slverr, apb_busy;
  logic [6:0]  apb_addr;
  logic [31:0] apb_wdata, apb_rdata;
  logic        rx_empty, last_byte, in_txn, timeout, abort;
  logic        unused_rdata_hi;

  apb_master_port u_apb (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .start   (apb_start),
    .write   (apb_write),
    .addr    (apb_addr),
    .wdata   (apb_wdata),
    .done    (apb_done),
    .rdata   (apb_rdata),
    .slverr  (apb_slverr),
    .busy    (apb_busy),
    .psel    (m_psel),
    .penable (m_penable),
    .pwrite  (m_pwrite),
    .paddr   (m_paddr),
    .pwdata  (m_pwdata),
    .prdata  (m_prdata),
    .pready  (m_pready),
    .pslverr (m_pslverr)
  );

  assign unused_rdata_hi = ^apb_rdata[31:8];
  assign rx_empty  = apb_rdata[STATUS_RXEMPTY];
  assign last_byte = (idx == ({1'b0, len_q} + HDR_BYTES));
  assign in_txn    = (state == ST_SSEL_ON) || (state == ST_TX_WR) ||
                     (state == ST_POLL)    || (state == ST_RX_RD);
  assign timeout   = (state == ST_POLL) && apb_done && !apb_slverr && rx_empty &&
                     (poll_cnt == 16'(POLL_LIMIT - 1));
  assign abort     = (in_txn && apb_slverr) || timeout;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= ST_INIT_CLK;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT_CLK:  if (apb_done) state_nx = ST_INIT_CTRL;
      ST_INIT_CTRL: if (apb_done) state_nx = ST_IDLE;
      ST_IDLE:      if (req_valid) state_nx = ST_SSEL_ON;
      ST_SSEL_ON:   if (apb_done) state_nx = ST_TX_WR;
      ST_TX_WR:     if (apb_done) state_nx = ST_POLL;
      ST_POLL:      if (apb_done && !rx_empty) state_nx = ST_RX_RD;
      ST_RX_RD:     if (apb_done) state_nx = (idx < HDR_BYTES) ? ST_TX_WR : ST_OUT;
      ST_OUT:       if (rd_ready) state_nx = last_byte ? ST_SSEL_OFF : ST_TX_WR;
      ST_SSEL_OFF:  if (apb_done) state_nx = ST_IDLE;
      default:      state_nx = ST_INIT_CLK;
    endcase
    if (abort) state_nx = ST_SSEL_OFF;
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    rd_valid  = 1'b0;
    access    = 1'b0;
    apb_write = 1'b1;
    apb_addr  = REG_CONTROL;
    apb_wdata = '0;
    case (state)
      ST_INIT_CLK:  begin access = 1'b1; apb_addr = REG_CLKGEN; apb_wdata = 32'(CLKGEN_DIV); end
      ST_INIT_CTRL: begin access = 1'b1; apb_addr = REG_CONTROL; apb_wdata = CONTROL_INIT; end
      ST_IDLE:      req_ready = 1'b1;
      ST_SSEL_ON:   begin busy = 1'b1; access = 1'b1; apb_addr = REG_SSEL; apb_wdata = 32'h1; end
      ST_TX_WR: begin
        busy      = 1'b1;
        access    = 1'b1;
        apb_addr  = REG_TXDATA;
        apb_wdata = {24'd0, tx_byte(idx, cmd_q, addr_q)};
      end
      ST_POLL:      begin busy = 1'b1; access = 1'b1; apb_write = 1'b0; apb_addr = REG_STATUS; end
      ST_RX_RD:     begin busy = 1'b1; access = 1'b1; apb_write = 1'b0; apb_addr = REG_RXDATA; end
      ST_OUT:       begin busy = 1'b1; rd_valid = 1'b1; end
      ST_SSEL_OFF:  begin busy = 1'b1; access = 1'b1; apb_addr = REG_SSEL; end
      default:      ;
    endcase
  end

  assign apb_start = access & ~apb_busy;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cmd_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      idx      <= '0;
      poll_cnt <= '0;
      err_flag <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == ST_IDLE && req_valid) begin
        cmd_q    <= req_cmd;
        addr_q   <= req_addr;
        len_q    <= req_len;
        idx      <= '0;
        err_flag <= 1'b0;
      end
      if (state == ST_RX_RD && apb_done && !apb_slverr) begin
        if (idx < HDR_BYTES) idx <= idx + 9'd1;
        else                 rd_data <= apb_rdata[7:0];
      end
      if (state == ST_OUT && rd_ready && !last_byte) idx <= idx + 9'd1;
      if (state != ST_POLL)  poll_cnt <= '0;
      else if (apb_done)     poll_cnt <= poll_cnt + 16'd1;
      if (abort) err_flag <= 1'b1;
      if (state == ST_SSEL_OFF && apb_done) begin
        done <= 1'b1;
        err  <= err_flag | apb_slverr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_sequencer.sv
// tb_spi_flash_sequencer: directed bench with an APB/CoreSPI model and a byte-stream consumer.
// Revision: 1.0
`default_nettype none

module tb_spi_flash_sequencer;
  import spi_seq_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        req_valid, req_ready;
  logic [7:0]  req_cmd, req_len, rd_data;
  logic [23:0] req_addr;
  logic        rd_valid, rd_ready, busy, done, err;
  logic [6:0]  m_paddr;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [31:0] m_pwdata, m_prdata;

  spi_flash_sequencer #(.CLKGEN_DIV(4), .POLL_LIMIT(1023)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_len(req_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  // Knobs (main process only)
  bit         stuck_empty = 1'b0;
  bit         inject_err = 1'b0;
  bit         rand_ready = 1'b0;
  logic [7:0] base = 8'h00;

  // Model / monitor state (model and consumer processes only)
  logic [7:0]  rx_q[$];
  logic [6:0]  wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [7:0]  got[$];
  int          tx_cnt = 0;
  bit          first_poll = 1'b0;
  int          status_reads = 0;
  int          stab_err = 0;

  // Snapshots (main process only)
  int lw, g0, s0, st0;
  bit err_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_tx(input int k, input logic [7:0] c, input logic [23:0] a);
    if (k == 0) return c;
    if (k == 1) return a[23:16];
    if (k == 2) return a[15:8];
    if (k == 3) return a[7:0];
    return 8'h00;
  endfunction

  // CoreSPI APB slave model, evaluated at the falling edge so prdata/pslverr are settled for the rising edge.
  initial begin
    m_prdata  = '0;
    m_pslverr = 1'b0;
    m_pready  = 1'b1;
    forever begin
      @(negedge PCLK);
      m_pslverr = 1'b0;
      if (!PRESETN) begin
        rx_q.delete();
        tx_cnt     = 0;
        first_poll = 1'b0;
        m_prdata   = '0;
      end else if (m_psel && m_penable) begin
        m_prdata = '0;
        if (!m_pwrite && m_paddr == REG_STATUS) begin
          status_reads++;
          m_prdata   = {29'd0, (stuck_empty || first_poll || rx_q.size() == 0), 2'b00};
          first_poll = 1'b0;
        end
        if (!m_pwrite && m_paddr == REG_RXDATA && rx_q.size() != 0)
          m_prdata = {24'd0, rx_q.pop_front()};
        if (m_pwrite) begin
          if (inject_err && m_paddr == REG_TXDATA && tx_cnt == 2) m_pslverr = 1'b1;
          wr_addr_log.push_back(m_paddr);
          wr_data_log.push_back(m_pwdata);
          if (m_paddr == REG_SSEL && m_pwdata[0]) begin
            rx_q.delete();
            tx_cnt = 0;
          end
          if (m_paddr == REG_TXDATA && !m_pslverr) begin
            rx_q.push_back(tx_cnt < 4 ? 8'hEE : base + 8'(tx_cnt - 4));
            tx_cnt++;
            first_poll = 1'b1;
          end
        end
      end
    end
  end

  // Byte-stream consumer: handshake happens on the rising edge following this falling edge.
  initial begin
    bit         hold_pending = 1'b0;
    logic [7:0] hold_data = 8'h00;
    rd_ready = 1'b0;
    forever begin
      @(negedge PCLK);
      if (hold_pending && rd_valid && rd_data != hold_data) stab_err++;
      rd_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rd_valid && rd_ready) got.push_back(rd_data);
      hold_pending = rd_valid && !rd_ready;
      hold_data    = rd_data;
    end
  end

  task automatic do_reset();
    int cyc = 0;
    int l0;
    logic [31:0] d0, d1;
    logic [6:0]  a0, a1;
    PRESETN   = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_values", {req_ready, rd_valid, rd_data, busy, done, err, m_psel, m_penable,
                           m_pwrite, m_paddr, m_pwdata}, 64'd0);
    l0 = wr_addr_log.size();
    PRESETN = 1'b1;
    while (!req_ready && cyc < 20) begin
      @(negedge PCLK);
      cyc++;
    end
    check("init_ready_within_7", (req_ready && cyc <= 7), 1);
    check("init_write_count", wr_addr_log.size() - l0, 2);
    a0 = 7'h7F; a1 = 7'h7F; d0 = '1; d1 = '1;
    if (wr_addr_log.size() >= l0 + 2) begin
      a0 = wr_addr_log[l0];     d0 = wr_data_log[l0];
      a1 = wr_addr_log[l0 + 1]; d1 = wr_data_log[l0 + 1];
    end
    check("init_clkgen", {a0, d0}, {7'h30, 32'd4});
    check("init_control", {a1, d1}, {7'h00, 32'h3});
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input logic [7:0] len);
    int cyc = 0;
    lw = wr_addr_log.size();
    g0 = got.size();
    s0 = status_reads;
    st0 = stab_err;
    err_seen = 1'b0;
    while (!req_ready && cyc < 50) begin
      @(negedge PCLK);
      cyc++;
    end
    req_cmd = cmd; req_addr = addr; req_len = len; req_valid = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b0;
    check("busy_on_accept", {busy, req_ready}, {1'b1, 1'b0});
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge PCLK);
      cyc++;
    end
    check("done_seen", done, 1);
    err_seen = err;
    @(negedge PCLK);
    check("done_single_cycle", {done, err, busy, req_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic verify(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                        input int exp_ntx, input int exp_nbytes, input bit exp_err);
    int ntx = 0, txbad = 0, nss = 0, bad = 0;
    logic [31:0] ss0 = '1, ss1 = '1;
    for (int i = lw; i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] == REG_TXDATA) begin
        if (wr_data_log[i] != {24'd0, exp_tx(ntx, cmd, addr)}) txbad++;
        ntx++;
      end
      if (wr_addr_log[i] == REG_SSEL) begin
        if (nss == 0) ss0 = wr_data_log[i];
        else          ss1 = wr_data_log[i];
        nss++;
      end
    end
    check({tag, "_tx_count"}, ntx, exp_ntx);
    check({tag, "_tx_bytes_bad"}, txbad, 0);
    check({tag, "_ssel_on_off"}, {nss, ss0, ss1}, {32'd2, 32'd1, 32'd0});
    check({tag, "_rx_count"}, got.size() - g0, exp_nbytes);
    for (int i = 0; i < got.size() - g0; i++)
      if (got[g0 + i] != base + 8'(i)) bad++;
    check({tag, "_rx_bytes_bad"}, bad, 0);
    check({tag, "_err"}, err_seen, exp_err);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [7:0]  base;
    int          exp_ntx;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int cyc;
    logic [8:0] first_b, last_b;
    req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_len = '0;
    vecs[0] = '{8'h03, 24'h123456, 8'd0, 8'hA5, 5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h0B, 24'hABCDEF, 8'd3, 8'h10, 8, 8'h10, 8'h13};
    vecs[2] = '{8'h03, 24'h000000, 8'd1, 8'hFF, 6, 8'hFF, 8'h00};

    do_reset();

    for (int v = 0; v < 3; v++) begin
      base = vecs[v].base;
      run_txn(vecs[v].cmd, vecs[v].addr, vecs[v].len);
      verify($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].addr, vecs[v].exp_ntx,
             int'(vecs[v].len) + 1, 1'b0);
      first_b = (got.size() > g0) ? {1'b0, got[g0]} : 9'h1FF;
      last_b  = (got.size() > g0) ? {1'b0, got[got.size() - 1]} : 9'h1FF;
      check($sformatf("vec%0d_first_last", v), {first_b, last_b},
            {1'b0, vecs[v].exp_first, 1'b0, vecs[v].exp_last});
    end

    // 256-byte read with a stalling consumer
    base = 8'h00;
    rand_ready = 1'b1;
    run_txn(8'h03, 24'h000100, 8'd255);
    rand_ready = 1'b0;
    verify("len256", 8'h03, 24'h000100, 260, 256, 1'b0);
    check("len256_rd_data_stable", stab_err - st0, 0);

    // RXEMPTY never clears: poll timeout
    stuck_empty = 1'b1;
    run_txn(8'h03, 24'h00ABCD, 8'd0);
    stuck_empty = 1'b0;
    verify("timeout", 8'h03, 24'h00ABCD, 1, 0, 1'b1);
    check("timeout_poll_count", status_reads - s0, 1023);

    // Slave error on the idx2 TXDATA write, then a clean request
    inject_err = 1'b1;
    run_txn(8'h03, 24'h654321, 8'd4);
    inject_err = 1'b0;
    verify("slverr", 8'h03, 24'h654321, 3, 0, 1'b1);
    base = 8'h40;
    run_txn(8'h03, 24'h000010, 8'd2);
    verify("after_err", 8'h03, 24'h000010, 7, 3, 1'b0);

    // Reset while polling
    stuck_empty = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge PCLK);
      cyc++;
    end
    req_cmd = 8'h03; req_addr = 24'h111111; req_len = 8'd0; req_valid = 1'b1;
    @(negedge PCLK);
    req_valid = 1'b0;
    cyc = 0;
    while (!(m_psel && m_paddr == REG_STATUS) && cyc < 200) begin
      @(negedge PCLK);
      cyc++;
    end
    check("reached_poll", (m_psel && m_paddr == REG_STATUS), 1);
    #2 PRESETN = 1'b0;
    #1;
    check("reset_mid_apb", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, busy, rd_valid}, 64'd0);
    stuck_empty = 1'b0;
    @(negedge PCLK);
    do_reset();
    base = 8'h77;
    run_txn(8'h03, 24'h222222, 8'd1);
    verify("post_reset", 8'h03, 24'h222222, 6, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
